spike_rate_encoder: RTL and testbench

SPIKE_RATE_ENCODER -- requirements
Module: spike_rate_encoder

---
 rtl/spike_rate_encoder.sv | 114 +++++++++++
 tb/tb_spike_rate_encoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_encoder.sv
// Rate-coded spike encoder: each timestep scans the channels one per cycle, compares a
// shared random sample against each channel's rate word, and hands the spike vector downstream.
module spike_rate_encoder #(
  parameter int N_CH   = 8,
  parameter int RAND_W = 20,
  parameter int REFRAC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [RAND_W-1:0]       rand_in,
  input  logic                    run,
  input  logic                    rate_wr_en,
  input  logic [$clog2(N_CH)-1:0] rate_wr_addr,
  input  logic [RAND_W-1:0]       rate_wr_data,
  output logic [N_CH-1:0]         spikes_out,
  output logic                    spikes_valid,
  input  logic                    spikes_ready,
  output logic                    busy,
  output logic [15:0]             step_count
);

  localparam int CH_W = $clog2(N_CH);
  localparam int RF_W = (REFRAC > 1) ? $clog2(REFRAC + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state;
  logic [CH_W-1:0]   ch;
  logic [N_CH-1:0]   acc;
  logic [RAND_W-1:0] rate   [N_CH];
  logic [RF_W-1:0]   refrac [N_CH];

  logic [RAND_W-1:0] cur_rate;
  logic [RF_W-1:0]   cur_refrac;
  logic              spike_bit;
  logic              last_ch;
  logic [N_CH-1:0]   acc_next;

  // Evaluation of the channel currently addressed by ch; the rate read here is the
  // pre-write value, so a same-cycle write only affects later evaluations.
  always_comb begin
    cur_rate   = rate[ch];
    cur_refrac = refrac[ch];
    spike_bit  = (cur_refrac == '0) && (rand_in < cur_rate);
    last_ch    = (ch == CH_W'(N_CH - 1));
    acc_next   = acc | (N_CH'(spike_bit) << ch);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ch           <= '0;
      acc          <= '0;
      spikes_out   <= '0;
      spikes_valid <= 1'b0;
      step_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state <= SCAN;
            ch    <= '0;
            acc   <= '0;
          end
        end
        SCAN: begin
          acc <= acc_next;
          if (last_ch) begin
            state        <= HOLD;
            spikes_out   <= acc_next;
            spikes_valid <= 1'b1;
            ch           <= '0;
            acc          <= '0;
          end else begin
            ch <= ch + CH_W'(1);
          end
        end
        HOLD: begin
          if (spikes_ready) begin
            spikes_valid <= 1'b0;
            step_count   <= step_count + 16'd1;
            state        <= run ? SCAN : IDLE;
            ch           <= '0;
            acc          <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Out-of-range addresses can occur when N_CH is not a power of two; those writes are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) rate[i] <= '0;
    end else if (rate_wr_en && (int'(rate_wr_addr) < N_CH)) begin
      rate[rate_wr_addr] <= rate_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) refrac[i] <= '0;
    end else if (state == SCAN) begin
      if (cur_refrac != '0) refrac[ch] <= cur_refrac - RF_W'(1);
      else if (spike_bit)   refrac[ch] <= RF_W'(REFRAC);
    end
  end

  assign busy = (state == SCAN) || (state == HOLD);

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Randomized bench for spike_rate_encoder against a timestep-level reference model.
module tb_spike_rate_encoder;

  localparam int N_CH   = 5;
  localparam int RAND_W = 20;
  localparam int REFRAC = 2;
  localparam int CH_W   = $clog2(N_CH);
  localparam int MAXR   = (1 << RAND_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [RAND_W-1:0] rand_in = '0;
  logic              run = 1'b0;
  logic              rate_wr_en = 1'b0;
  logic [CH_W-1:0]   rate_wr_addr = '0;
  logic [RAND_W-1:0] rate_wr_data = '0;
  logic [N_CH-1:0]   spikes_out;
  logic              spikes_valid;
  logic              spikes_ready = 1'b0;
  logic              busy;
  logic [15:0]       step_count;

  spike_rate_encoder #(.N_CH(N_CH), .RAND_W(RAND_W), .REFRAC(REFRAC)) dut (
    .clk(clk), .rst(rst), .rand_in(rand_in), .run(run),
    .rate_wr_en(rate_wr_en), .rate_wr_addr(rate_wr_addr), .rate_wr_data(rate_wr_data),
    .spikes_out(spikes_out), .spikes_valid(spikes_valid), .spikes_ready(spikes_ready),
    .busy(busy), .step_count(step_count)
  );

  always #5 clk = ~clk;

  int unsigned     mrate [N_CH];
  int              mref  [N_CH];
  int              mcount;
  logic [N_CH-1:0] last_out;
  int              checks = 0;
  int              errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick_val();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return MAXR;
      default: return int'($urandom & MAXR);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin mrate[i] = 0; mref[i] = 0; end
    mcount   = 0;
    last_out = '0;
  endtask

  task automatic model_write(input int a, input int d);
    if (a < N_CH) mrate[a] = d;
  endtask

  task automatic drive_rand_write();
    int a, d;
    rate_wr_en = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      a = $urandom_range(0, (1 << CH_W) - 1);
      d = pick_val();
      rate_wr_en   = 1'b1;
      rate_wr_addr = CH_W'(a);
      rate_wr_data = RAND_W'(d);
      model_write(a, d);
    end
  endtask

  // Reset is applied with every other input active to show it dominates.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b1; spikes_ready = 1'b1;
    rate_wr_en = 1'b1; rate_wr_addr = '0; rate_wr_data = RAND_W'(MAXR);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", spikes_valid, 0);
    chk("rst_out", spikes_out, 0);
    chk("rst_count", step_count, 0);
    rst = 1'b0; run = 1'b0; rate_wr_en = 1'b0; spikes_ready = 1'b0;
    model_reset();
  endtask

  task automatic write_rate(input int a, input int d);
    @(negedge clk);
    run = 1'b0;
    rate_wr_en = 1'b1; rate_wr_addr = CH_W'(a); rate_wr_data = RAND_W'(d);
    model_write(a, d);
  endtask

  // wr_mode: 0 no writes, 1 random writes, 2 one write at scan index wr_k.
  task automatic run_step(input bit from_idle, input int fixed_rand, input int wr_mode,
                          input int wr_k, input int wr_a, input int wr_d,
                          input int hold_n, input bit run_after, output logic [N_CH-1:0] got);
    logic [N_CH-1:0] exp;
    int r;
    bit b;
    exp = '0;
    if (from_idle) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_valid", spikes_valid, 0);
      run = 1'b1; rate_wr_en = 1'b0; spikes_ready = 1'($urandom);
    end
    for (int k = 0; k < N_CH; k++) begin
      @(negedge clk);
      chk("scan_busy", busy, 1);
      chk("scan_valid", spikes_valid, 0);
      chk("scan_out_stable", spikes_out, last_out);
      r = (fixed_rand >= 0) ? fixed_rand : pick_val();
      rand_in = RAND_W'(r);
      run = 1'($urandom);
      spikes_ready = 1'($urandom);
      if (mref[k] != 0) begin
        b = 1'b0;
        mref[k]--;
      end else begin
        b = (r < mrate[k]);
        if (b) mref[k] = REFRAC;
      end
      exp[k] = b;
      rate_wr_en = 1'b0;
      if (wr_mode == 1) drive_rand_write();
      else if (wr_mode == 2 && k == wr_k) begin
        rate_wr_en = 1'b1; rate_wr_addr = CH_W'(wr_a); rate_wr_data = RAND_W'(wr_d);
        model_write(wr_a, wr_d);
      end
    end
    for (int h = 0; h <= hold_n; h++) begin
      @(negedge clk);
      chk("hold_valid", spikes_valid, 1);
      chk("hold_out", spikes_out, exp);
      chk("hold_busy", busy, 1);
      chk("hold_count", step_count, mcount);
      rand_in = RAND_W'(pick_val());
      rate_wr_en = 1'b0;
      if (wr_mode == 1) drive_rand_write();
      if (h == hold_n) begin spikes_ready = 1'b1; run = run_after; end
      else begin spikes_ready = 1'b0; run = 1'($urandom); end
    end
    mcount   = (mcount + 1) & 16'hFFFF;
    last_out = exp;
    got      = exp;
  endtask

  initial begin
    logic [N_CH-1:0] got;
    bit prev_run;
    bit ra;
    model_reset();
    do_reset();

    // All-zero rates: no spikes, counter climbs step by step.
    run_step(1, -1, 0, 0, 0, 0, 0, 1, got);
    chk("zero_rates_s1", got, 0);
    run_step(0, -1, 0, 0, 0, 0, 0, 1, got);
    chk("zero_rates_s2", got, 0);
    run_step(0, -1, 0, 0, 0, 0, 0, 0, got);
    chk("zero_rates_s3", got, 0);
    @(negedge clk);
    chk("count_after_3", step_count, 3);

    // Saturated rates with rand_in=0: refractory pattern 1,0,0 repeating.
    do_reset();
    write_rate(0, MAXR);
    write_rate(2, MAXR);
    write_rate(6, MAXR);
    for (int s = 0; s < 6; s++) begin
      run_step(s == 0, 0, 0, 0, 0, 0, (s == 3) ? 10 : 0, s != 5, got);
      chk("refrac_ch0", got[0], (s % 3) == 0);
      chk("refrac_ch2", got[2], (s % 3) == 0);
      chk("rate0_ch1", got[1], 0);
    end

    // Rand all-ones never spikes even at max rate.
    run_step(1, MAXR, 0, 0, 0, 0, 0, 0, got);
    chk("allones_no_spike", got, 0);

    // Same-cycle write uses the old rate; the new one applies next step.
    do_reset();
    run_step(1, 5, 2, 1, 1, MAXR, 0, 1, got);
    chk("wr_same_cycle_old", got[1], 0);
    run_step(0, 5, 0, 0, 0, 0, 0, 0, got);
    chk("wr_next_step_new", got[1], 1);

    // Reset in the middle of a scan discards everything.
    write_rate(3, MAXR);
    @(negedge clk);
    rate_wr_en = 1'b0; run = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rand_in = '0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midscan_busy", busy, 0);
    chk("midscan_valid", spikes_valid, 0);
    chk("midscan_count", step_count, 0);
    chk("midscan_out", spikes_out, 0);
    rst = 1'b0; run = 1'b1;
    model_reset();
    run_step(0, 0, 0, 0, 0, 0, 0, 1, got);
    chk("post_rst_zero1", got, 0);
    run_step(0, 0, 0, 0, 0, 0, 0, 0, got);
    chk("post_rst_zero2", got, 0);

    // Randomized traffic with writes, stalls and run toggling.
    prev_run = 1'b0;
    for (int s = 0; s < 60; s++) begin
      ra = ($urandom_range(0, 3) != 0);
      run_step(!prev_run, -1, 1, 0, 0, 0, $urandom_range(0, 3), ra, got);
      prev_run = ra;
    end
    @(negedge clk);
    chk("final_count", step_count, mcount);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
